// File: rtl/ct_idu_viq_pkg.sv
// Shared definitions for the vector issue queue entry: the entry state
// encoding and the bit offsets of the 12-bit vreg dependency read bus.
package ct_idu_viq_pkg;

    // Entry life cycle: allocated -> waiting for operands -> issued/cancellable.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        WAIT   = 2'b01,
        ISSUED = 2'b10
    } entry_state_e;

    // Field offsets inside one source's dependency read bus.
    localparam int LSU_MATCH = 11;
    localparam int RDY_BYP   = 10;
    localparam int RDY_ISS   = 9;
    localparam int VREG_LSB  = 2;
    localparam int VREG_W    = 7;
    localparam int WB        = 1;
    localparam int RDY       = 0;

endpackage

// File: rtl/ct_idu_viq_entry_ctrl_if.sv
// Bundle between one issue-queue entry controller and its neighbours
// (dispatch/create, three dependency entries, the issue arbiter, RTU, LSU).
//
// Handshakes:
//  - create: x_create_en is a single-cycle strobe that may only be raised
//    while the entry is empty (x_entry_vld == 0); the entry answers in the
//    same cycle with x_dep_write_en to its dependency entries.
//  - issue: x_issue_req is the valid, x_issue_grant the ready; a transfer
//    happens only in a cycle where both are high. A grant while the request
//    is low is ignored.
interface ct_idu_viq_entry_ctrl_if
    import ct_idu_viq_pkg::*;
#(
    parameter int SRC_NUM = 3,
    parameter int DEP_W   = 12
) ();

    logic                       rtu_idu_flush_fe;
    logic                       rtu_idu_flush_is;
    logic                       x_create_en;
    logic [SRC_NUM-1:0]         x_create_src_vld;
    logic [SRC_NUM*DEP_W-1:0]   x_dep_read_data;
    logic                       x_issue_grant;
    logic                       lsu_idu_vload_spec_fail;

    logic [SRC_NUM-1:0]         x_dep_write_en;
    logic [SRC_NUM-1:0]         x_dep_rdy_clr;
    logic                       x_entry_vld;
    logic                       x_issue_req;
    logic                       x_entry_free;
    entry_state_e               x_entry_state;   // debug view of the entry FSM

    // Upstream side: drives control into the entry, observes its outputs.
    modport master (
        output rtu_idu_flush_fe, rtu_idu_flush_is, x_create_en, x_create_src_vld,
               x_dep_read_data, x_issue_grant, lsu_idu_vload_spec_fail,
        input  x_dep_write_en, x_dep_rdy_clr, x_entry_vld, x_issue_req,
               x_entry_free, x_entry_state
    );

    // Entry side.
    modport slave (
        input  rtu_idu_flush_fe, rtu_idu_flush_is, x_create_en, x_create_src_vld,
               x_dep_read_data, x_issue_grant, lsu_idu_vload_spec_fail,
        output x_dep_write_en, x_dep_rdy_clr, x_entry_vld, x_issue_req,
               x_entry_free, x_entry_state
    );

endinterface

// File: rtl/ct_idu_viq_src_eval.sv
// Per-source decode of one dependency read bus: whether the source lets the
// entry issue, and whether it would issue on an LSU forward (ready for issue
// but not yet ready for bypass), which makes it cancellable by a load
// speculation fail.
module ct_idu_viq_src_eval
    import ct_idu_viq_pkg::*;
#(
    parameter int DEP_W = 12
) (
    input  logic             src_vld,
    input  logic [DEP_W-1:0] rd,
    output logic             src_ok,
    output logic             fwd_issue
);

    assign src_ok    = !src_vld || rd[RDY_ISS];
    assign fwd_issue = src_vld && rd[RDY_ISS] && !rd[RDY_BYP];

    // Remaining fields are owned by the dependency entry and not needed here.
    logic unused_fields;
    assign unused_fields = ^{rd[LSU_MATCH], rd[VREG_LSB +: VREG_W], rd[WB], rd[RDY]};

endmodule

// File: rtl/ct_idu_viq_entry_ctrl.sv
// Vector issue queue entry control: create, wait for operands, request issue,
// then hold for a short load-speculation window in which an LSU spec fail can
// send the entry back to WAIT and clear the ready bits of forwarded sources.
module ct_idu_viq_entry_ctrl
    import ct_idu_viq_pkg::*;
#(
    parameter int SRC_NUM  = 3,
    parameter int DEP_W    = 12,
    parameter int SPEC_WIN = 2
) (
    input logic                     dep_clk,
    input logic                     cpurst_b,
    ct_idu_viq_entry_ctrl_if.slave  entry_if
);

    localparam int CNT_W = $clog2(SPEC_WIN) + 1;

    entry_state_e        state, state_nxt;
    logic [SRC_NUM-1:0]  src_vld, src_vld_nxt;
    logic [SRC_NUM-1:0]  spec_mask, spec_mask_nxt;
    logic [CNT_W-1:0]    spec_cnt, spec_cnt_nxt;

    logic [SRC_NUM-1:0]  src_ok;
    logic [SRC_NUM-1:0]  fwd_issue;
    logic [SRC_NUM-1:0]  dep_write_en;
    logic [SRC_NUM-1:0]  dep_rdy_clr;
    logic                issue_req;
    logic                entry_free;
    logic                flush;

    assign flush = entry_if.rtu_idu_flush_fe || entry_if.rtu_idu_flush_is;

    for (genvar i = 0; i < SRC_NUM; i++) begin : g_src
        ct_idu_viq_src_eval #(
            .DEP_W (DEP_W)
        ) u_src_eval (
            .src_vld   (src_vld[i]),
            .rd        (entry_if.x_dep_read_data[i*DEP_W +: DEP_W]),
            .src_ok    (src_ok[i]),
            .fwd_issue (fwd_issue[i])
        );
    end

    // Next-state and strobe decode; flush overrides every state at the end.
    always_comb begin
        state_nxt     = state;
        src_vld_nxt   = src_vld;
        spec_mask_nxt = spec_mask;
        spec_cnt_nxt  = spec_cnt;
        dep_write_en  = '0;
        dep_rdy_clr   = '0;
        issue_req     = 1'b0;
        entry_free    = 1'b0;

        case (state)
            EMPTY: begin
                if (entry_if.x_create_en && !flush) begin
                    state_nxt    = WAIT;
                    src_vld_nxt  = entry_if.x_create_src_vld;
                    dep_write_en = {SRC_NUM{1'b1}};
                end
            end
            WAIT: begin
                issue_req = &src_ok;
                if (entry_if.x_issue_grant && issue_req) begin
                    state_nxt     = ISSUED;
                    spec_cnt_nxt  = CNT_W'(SPEC_WIN - 1);
                    spec_mask_nxt = fwd_issue;
                end
            end
            ISSUED: begin
                // A cancel beats counter expiry: the entry must stay valid.
                if (entry_if.lsu_idu_vload_spec_fail && (|spec_mask)) begin
                    state_nxt     = WAIT;
                    dep_rdy_clr   = spec_mask;
                    spec_mask_nxt = '0;
                end else if (spec_cnt == '0) begin
                    state_nxt     = EMPTY;
                    entry_free    = 1'b1;
                    src_vld_nxt   = '0;
                    spec_mask_nxt = '0;
                end else begin
                    spec_cnt_nxt  = spec_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase

        if (flush) begin
            state_nxt     = EMPTY;
            src_vld_nxt   = '0;
            spec_mask_nxt = '0;
            spec_cnt_nxt  = '0;
            dep_write_en  = '0;
            dep_rdy_clr   = '0;
            entry_free    = 1'b0;
        end
    end

    // Entry state, source valids, speculation mask and window counter.
    always_ff @(posedge dep_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state     <= EMPTY;
            src_vld   <= '0;
            spec_mask <= '0;
            spec_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            src_vld   <= src_vld_nxt;
            spec_mask <= spec_mask_nxt;
            spec_cnt  <= spec_cnt_nxt;
        end
    end

    assign entry_if.x_dep_write_en = dep_write_en;
    assign entry_if.x_dep_rdy_clr  = dep_rdy_clr;
    assign entry_if.x_entry_vld    = (state != EMPTY);
    assign entry_if.x_issue_req    = issue_req;
    assign entry_if.x_entry_free   = entry_free;
    assign entry_if.x_entry_state  = state;

    // Dispatch must never allocate an entry that is still occupied.
    a_no_create_when_busy: assert property (
        @(posedge dep_clk) disable iff (!cpurst_b)
        !(entry_if.x_create_en && (state != EMPTY))
    );

endmodule

// File: tb/tb_ct_idu_viq_entry_ctrl.sv
// Bench for the vector issue queue entry controller: directed scenarios for
// reset, issue, speculation cancel, flush and async reset, then a randomized
// run checked against a cycle-level behavioural model of the entry.
module tb_ct_idu_viq_entry_ctrl;
    import ct_idu_viq_pkg::*;

    localparam int SRC_NUM  = 3;
    localparam int DEP_W    = 12;
    localparam int SPEC_WIN = 2;

    logic dep_clk  = 1'b0;
    logic cpurst_b = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    ct_idu_viq_entry_ctrl_if #(.SRC_NUM(SRC_NUM), .DEP_W(DEP_W)) vif ();

    ct_idu_viq_entry_ctrl #(
        .SRC_NUM  (SRC_NUM),
        .DEP_W    (DEP_W),
        .SPEC_WIN (SPEC_WIN)
    ) dut (
        .dep_clk  (dep_clk),
        .cpurst_b (cpurst_b),
        .entry_if (vif)
    );

    // Clock and reset
    always #5 dep_clk = ~dep_clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Driver helpers
    function automatic logic [DEP_W-1:0] mk_rd(input logic iss, input logic byp);
        logic [DEP_W-1:0] r;
        r = '0;
        r[RDY_ISS] = iss;
        r[RDY_BYP] = byp;
        return r;
    endfunction

    task automatic clear_inputs();
        vif.rtu_idu_flush_fe        = 1'b0;
        vif.rtu_idu_flush_is        = 1'b0;
        vif.x_create_en             = 1'b0;
        vif.x_create_src_vld        = '0;
        vif.x_dep_read_data         = '0;
        vif.x_issue_grant           = 1'b0;
        vif.lsu_idu_vload_spec_fail = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge dep_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge dep_clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        cpurst_b = 1'b0;
        repeat (3) @(posedge dep_clk);
        sample();
        checks++;
        if ({vif.x_entry_vld, vif.x_issue_req, vif.x_dep_write_en, vif.x_dep_rdy_clr, vif.x_entry_free} !== '0) begin
            errors++; $display("FAIL reset_outputs got vld=%b req=%b wen=%b clr=%b free=%b exp all 0",
                vif.x_entry_vld, vif.x_issue_req, vif.x_dep_write_en, vif.x_dep_rdy_clr, vif.x_entry_free);
        end
        cpurst_b = 1'b1;
        next_cycle();
        sample();
        checks++;
        if ({vif.x_entry_vld, vif.x_issue_req, vif.x_dep_write_en, vif.x_dep_rdy_clr, vif.x_entry_free} !== '0) begin
            errors++; $display("FAIL idle_outputs got vld=%b req=%b wen=%b clr=%b free=%b exp all 0",
                vif.x_entry_vld, vif.x_issue_req, vif.x_dep_write_en, vif.x_dep_rdy_clr, vif.x_entry_free);
        end
        checks++;
        if (vif.x_entry_state !== EMPTY) begin
            errors++; $display("FAIL idle_state got %0d exp %0d", vif.x_entry_state, EMPTY);
        end
        next_cycle();
    endtask

    task automatic test_issue_basic();
        vif.x_create_en      = 1'b1;
        vif.x_create_src_vld = 3'b011;
        vif.x_dep_read_data  = {mk_rd(1'b0, 1'b1), mk_rd(1'b1, 1'b1), mk_rd(1'b0, 1'b1)};
        sample();
        checks++;
        if (vif.x_dep_write_en !== 3'b111) begin
            errors++; $display("FAIL basic_write_en got %b exp 111", vif.x_dep_write_en);
        end
        checks++;
        if (vif.x_entry_vld !== 1'b0) begin
            errors++; $display("FAIL basic_vld_on_create got %b exp 0", vif.x_entry_vld);
        end
        next_cycle();
        vif.x_create_en = 1'b0;
        sample();
        checks++;
        if (vif.x_issue_req !== 1'b0 || vif.x_entry_state !== WAIT) begin
            errors++; $display("FAIL basic_wait_not_ready got req=%b state=%0d exp req=0 state=1",
                vif.x_issue_req, vif.x_entry_state);
        end
        next_cycle();
        vif.x_dep_read_data = {mk_rd(1'b0, 1'b1), mk_rd(1'b1, 1'b1), mk_rd(1'b1, 1'b1)};
        vif.x_issue_grant   = 1'b1;
        sample();
        checks++;
        if (vif.x_issue_req !== 1'b1) begin
            errors++; $display("FAIL basic_req_same_cycle got %b exp 1", vif.x_issue_req);
        end
        next_cycle();
        vif.x_issue_grant = 1'b0;
        sample();
        checks++;
        if (vif.x_entry_state !== ISSUED || vif.x_entry_free !== 1'b0 || vif.x_issue_req !== 1'b0) begin
            errors++; $display("FAIL basic_issued got state=%0d free=%b req=%b exp state=2 free=0 req=0",
                vif.x_entry_state, vif.x_entry_free, vif.x_issue_req);
        end
        next_cycle();
        sample();
        checks++;
        if (vif.x_entry_free !== 1'b1) begin
            errors++; $display("FAIL basic_free_pulse got %b exp 1", vif.x_entry_free);
        end
        next_cycle();
        sample();
        checks++;
        if (vif.x_entry_vld !== 1'b0 || vif.x_entry_free !== 1'b0) begin
            errors++; $display("FAIL basic_after_free got vld=%b free=%b exp 0 0", vif.x_entry_vld, vif.x_entry_free);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_spec_cancel();
        vif.x_create_en      = 1'b1;
        vif.x_create_src_vld = 3'b001;
        vif.x_dep_read_data  = {mk_rd(1'b0, 1'b0), mk_rd(1'b0, 1'b0), mk_rd(1'b1, 1'b0)};
        next_cycle();
        vif.x_create_en   = 1'b0;
        vif.x_issue_grant = 1'b1;
        sample();
        checks++;
        if (vif.x_issue_req !== 1'b1) begin
            errors++; $display("FAIL cancel_req got %b exp 1", vif.x_issue_req);
        end
        next_cycle();
        vif.x_issue_grant           = 1'b0;
        vif.lsu_idu_vload_spec_fail = 1'b1;
        sample();
        checks++;
        if (vif.x_dep_rdy_clr !== 3'b001 || vif.x_entry_free !== 1'b0) begin
            errors++; $display("FAIL cancel_rdy_clr got clr=%b free=%b exp 001 0", vif.x_dep_rdy_clr, vif.x_entry_free);
        end
        next_cycle();
        vif.lsu_idu_vload_spec_fail = 1'b0;
        vif.x_dep_read_data = '0;
        sample();
        checks++;
        if (vif.x_entry_state !== WAIT || vif.x_entry_vld !== 1'b1 || vif.x_issue_req !== 1'b0) begin
            errors++; $display("FAIL cancel_back_to_wait got state=%0d vld=%b req=%b exp 1 1 0",
                vif.x_entry_state, vif.x_entry_vld, vif.x_issue_req);
        end
        next_cycle();
        vif.rtu_idu_flush_fe = 1'b1;
        sample();
        checks++;
        if ({vif.x_dep_write_en, vif.x_dep_rdy_clr, vif.x_entry_free} !== '0) begin
            errors++; $display("FAIL cancel_flush_strobes got wen=%b clr=%b free=%b exp 0",
                vif.x_dep_write_en, vif.x_dep_rdy_clr, vif.x_entry_free);
        end
        next_cycle();
        clear_inputs();
        sample();
        checks++;
        if (vif.x_entry_vld !== 1'b0) begin
            errors++; $display("FAIL cancel_flush_empty got vld=%b exp 0", vif.x_entry_vld);
        end
        next_cycle();
    endtask

    task automatic test_spec_fail_ignored();
        vif.x_create_en      = 1'b1;
        vif.x_create_src_vld = 3'b111;
        vif.x_dep_read_data  = {mk_rd(1'b1, 1'b1), mk_rd(1'b1, 1'b1), mk_rd(1'b1, 1'b1)};
        next_cycle();
        vif.x_create_en   = 1'b0;
        vif.x_issue_grant = 1'b1;
        next_cycle();
        vif.x_issue_grant           = 1'b0;
        vif.lsu_idu_vload_spec_fail = 1'b1;
        sample();
        checks++;
        if (vif.x_dep_rdy_clr !== 3'b000 || vif.x_entry_free !== 1'b0 || vif.x_entry_state !== ISSUED) begin
            errors++; $display("FAIL ignfail_first got clr=%b free=%b state=%0d exp 000 0 2",
                vif.x_dep_rdy_clr, vif.x_entry_free, vif.x_entry_state);
        end
        next_cycle();
        sample();
        checks++;
        if (vif.x_entry_free !== 1'b1 || vif.x_dep_rdy_clr !== 3'b000) begin
            errors++; $display("FAIL ignfail_free got free=%b clr=%b exp 1 000", vif.x_entry_free, vif.x_dep_rdy_clr);
        end
        next_cycle();
        clear_inputs();
        sample();
        checks++;
        if (vif.x_entry_vld !== 1'b0) begin
            errors++; $display("FAIL ignfail_empty got vld=%b exp 0", vif.x_entry_vld);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        vif.x_create_en      = 1'b1;
        vif.x_create_src_vld = 3'b001;
        vif.x_dep_read_data  = {mk_rd(1'b0, 1'b0), mk_rd(1'b0, 1'b0), mk_rd(1'b1, 1'b1)};
        next_cycle();
        vif.x_create_en   = 1'b0;
        vif.x_issue_grant = 1'b1;
        next_cycle();
        vif.x_issue_grant = 1'b0;
        next_cycle();
        vif.rtu_idu_flush_is = 1'b1;
        sample();
        checks++;
        if (vif.x_entry_free !== 1'b0 || vif.x_entry_vld !== 1'b1) begin
            errors++; $display("FAIL flush_expiry got free=%b vld=%b exp 0 1", vif.x_entry_free, vif.x_entry_vld);
        end
        next_cycle();
        vif.rtu_idu_flush_is = 1'b0;
        sample();
        checks++;
        if (vif.x_entry_state !== EMPTY || vif.x_entry_free !== 1'b0) begin
            errors++; $display("FAIL flush_to_empty got state=%0d free=%b exp 0 0", vif.x_entry_state, vif.x_entry_free);
        end
        next_cycle();
        vif.x_create_en      = 1'b1;
        vif.x_create_src_vld = 3'b111;
        vif.rtu_idu_flush_fe = 1'b1;
        sample();
        checks++;
        if (vif.x_dep_write_en !== 3'b000) begin
            errors++; $display("FAIL flush_create_wen got %b exp 000", vif.x_dep_write_en);
        end
        next_cycle();
        clear_inputs();
        sample();
        checks++;
        if (vif.x_entry_vld !== 1'b0) begin
            errors++; $display("FAIL flush_create_empty got vld=%b exp 0", vif.x_entry_vld);
        end
        next_cycle();
    endtask

    task automatic test_no_src_and_grant();
        vif.x_create_en      = 1'b1;
        vif.x_create_src_vld = 3'b000;
        sample();
        checks++;
        if (vif.x_issue_req !== 1'b0) begin
            errors++; $display("FAIL nosrc_req_on_create got %b exp 0", vif.x_issue_req);
        end
        next_cycle();
        vif.x_create_en = 1'b0;
        sample();
        checks++;
        if (vif.x_issue_req !== 1'b1) begin
            errors++; $display("FAIL nosrc_req_after got %b exp 1", vif.x_issue_req);
        end
        next_cycle();
        vif.rtu_idu_flush_fe = 1'b1;
        next_cycle();
        vif.rtu_idu_flush_fe = 1'b0;
        vif.x_create_en      = 1'b1;
        vif.x_create_src_vld = 3'b001;
        vif.x_dep_read_data  = '0;
        next_cycle();
        vif.x_create_en   = 1'b0;
        vif.x_issue_grant = 1'b1;
        sample();
        checks++;
        if (vif.x_issue_req !== 1'b0) begin
            errors++; $display("FAIL grant_noreq_req got %b exp 0", vif.x_issue_req);
        end
        next_cycle();
        vif.x_issue_grant = 1'b0;
        sample();
        checks++;
        if (vif.x_entry_state !== WAIT) begin
            errors++; $display("FAIL grant_noreq_state got %0d exp 1", vif.x_entry_state);
        end
        next_cycle();
        vif.rtu_idu_flush_is = 1'b1;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_async_reset();
        vif.x_create_en      = 1'b1;
        vif.x_create_src_vld = 3'b000;
        next_cycle();
        vif.x_create_en   = 1'b0;
        vif.x_issue_grant = 1'b1;
        next_cycle();
        vif.x_issue_grant = 1'b0;
        sample();
        checks++;
        if (vif.x_entry_state !== ISSUED) begin
            errors++; $display("FAIL areset_pre_state got %0d exp 2", vif.x_entry_state);
        end
        next_cycle();
        cpurst_b = 1'b0;
        #1;
        checks++;
        if (vif.x_entry_vld !== 1'b0 || vif.x_entry_free !== 1'b0 || vif.x_entry_state !== EMPTY) begin
            errors++; $display("FAIL areset_mid_issued got vld=%b free=%b state=%0d exp 0 0 0",
                vif.x_entry_vld, vif.x_entry_free, vif.x_entry_state);
        end
        sample();
        cpurst_b = 1'b1;
        next_cycle();
    endtask

    // Randomized run against a behavioural model of the entry. The model
    // tracks occupancy, whether the entry is in its speculation window, how
    // many cycles it has spent there, and which sources issued on a forward.
    task automatic test_random();
        bit                 m_busy   = 1'b0;
        bit                 m_issued = 1'b0;
        int                 m_age    = 0;
        logic [SRC_NUM-1:0] m_vld    = '0;
        logic [SRC_NUM-1:0] m_fwd    = '0;
        logic [SRC_NUM-1:0] iss, byp, e_wen, e_clr, cv;
        logic [DEP_W-1:0]   rd;
        logic               fl, cr, gr, sf, all_ok, e_req, e_free, cancel;
        for (int n = 0; n < 600; n++) begin
            vif.rtu_idu_flush_fe = ($urandom_range(0, 24) == 0);
            vif.rtu_idu_flush_is = ($urandom_range(0, 24) == 0);
            vif.x_create_en      = !m_busy && ($urandom_range(0, 2) == 0);
            vif.x_create_src_vld = SRC_NUM'($urandom_range(0, 7));
            vif.x_issue_grant    = $urandom_range(0, 1);
            vif.lsu_idu_vload_spec_fail = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < SRC_NUM; i++) begin
                rd = DEP_W'($urandom);
                rd[RDY_ISS] = ($urandom_range(0, 3) != 0);
                vif.x_dep_read_data[i*DEP_W +: DEP_W] = rd;
                iss[i] = rd[RDY_ISS];
                byp[i] = rd[RDY_BYP];
            end
            fl = vif.rtu_idu_flush_fe || vif.rtu_idu_flush_is;
            cr = vif.x_create_en;
            gr = vif.x_issue_grant;
            sf = vif.lsu_idu_vload_spec_fail;
            cv = vif.x_create_src_vld;

            all_ok = 1'b1;
            for (int i = 0; i < SRC_NUM; i++)
                if (m_vld[i] && !iss[i]) all_ok = 1'b0;
            e_req  = m_busy && !m_issued && all_ok;
            e_wen  = (!m_busy && cr && !fl) ? 3'b111 : 3'b000;
            cancel = m_issued && !fl && sf && (m_fwd != 0);
            e_clr  = cancel ? m_fwd : 3'b000;
            e_free = m_issued && !fl && !cancel && (m_age == SPEC_WIN);

            sample();
            checks++;
            if (vif.x_issue_req !== e_req) begin
                errors++; $display("FAIL rand_req cyc %0d got %b exp %b", n, vif.x_issue_req, e_req);
            end
            checks++;
            if (vif.x_dep_write_en !== e_wen) begin
                errors++; $display("FAIL rand_wen cyc %0d got %b exp %b", n, vif.x_dep_write_en, e_wen);
            end
            checks++;
            if (vif.x_dep_rdy_clr !== e_clr) begin
                errors++; $display("FAIL rand_clr cyc %0d got %b exp %b", n, vif.x_dep_rdy_clr, e_clr);
            end
            checks++;
            if (vif.x_entry_free !== e_free) begin
                errors++; $display("FAIL rand_free cyc %0d got %b exp %b", n, vif.x_entry_free, e_free);
            end
            checks++;
            if (vif.x_entry_vld !== m_busy) begin
                errors++; $display("FAIL rand_vld cyc %0d got %b exp %b", n, vif.x_entry_vld, m_busy);
            end

            if (fl) begin
                m_busy = 1'b0; m_issued = 1'b0; m_fwd = '0; m_vld = '0;
            end else if (!m_busy) begin
                if (cr) begin m_busy = 1'b1; m_vld = cv; end
            end else if (!m_issued) begin
                if (gr && e_req) begin
                    m_issued = 1'b1;
                    m_age    = 1;
                    m_fwd    = m_vld & iss & ~byp;
                end
            end else if (cancel) begin
                m_issued = 1'b0; m_fwd = '0;
            end else if (m_age == SPEC_WIN) begin
                m_busy = 1'b0; m_issued = 1'b0; m_fwd = '0; m_vld = '0;
            end else begin
                m_age++;
            end
            next_cycle();
        end
        clear_inputs();
        vif.rtu_idu_flush_fe = 1'b1;
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_issue_basic();
        test_spec_cancel();
        test_spec_fail_ignored();
        test_flush();
        test_no_src_and_grant();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
